ofmd_acc_ram: RTL and testbench

OFMD_ACC_RAM -- requirements
Module: ofmd_acc_ram

---
 rtl/ofmd_acc_ram.sv | 107 ++++++++++
 tb/tb_ofmd_acc_ram.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/ofmd_acc_ram.sv
// ofmd_acc_ram: single-port-write accumulate RAM with registered read and whole-array clear
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   wr_en/wr_acc/wr_addr/wr_data  write request (overwrite or saturating accumulate)
//   rd_en/rd_addr -> rd_data/rd_valid  registered read, one-cycle valid pulse
//   clear_start -> busy/clear_done     zero fill of every word, one word per cycle
//   sat_flag                   sticky accumulate-saturation indicator
module ofmd_acc_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              wr_acc,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              clear_start,
    output logic              busy,
    output logic              clear_done,
    output logic              sat_flag
);
    typedef enum logic {IDLE, CLEAR} state_t;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic              stage_v;
    logic              stage_acc;
    logic [ADDR_W-1:0] stage_addr;
    logic [DATA_W-1:0] stage_data;
    logic              idle;
    logic              clr_go;
    logic              wr_go;
    logic              rd_go;
    logic [DATA_W:0]   sum;
    logic              sat_ev;
    logic [DATA_W-1:0] commit_val;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;

    // A write arriving with clear_start is dropped so the clear never shares
    // the write port with a stage commit.
    always_comb begin
        idle       = (state == IDLE);
        clr_go     = idle && clear_start;
        wr_go      = idle && wr_en && !clear_start;
        rd_go      = idle && rd_en;
        sum        = {1'b0, mem[stage_addr]} + {1'b0, stage_data};
        sat_ev     = stage_v && stage_acc && sum[DATA_W];
        commit_val = !stage_acc ? stage_data : sum[DATA_W] ? '1 : sum[DATA_W-1:0];
        mem_we     = stage_v || !idle;
        mem_wa     = idle ? stage_addr : cnt;
        mem_wd     = idle ? commit_val : '0;
        busy       = !idle;
    end

    // Storage is deliberately not reset; aborting relies on the control registers.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            stage_v    <= 1'b0;
            stage_acc  <= 1'b0;
            stage_addr <= '0;
            stage_data <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            clear_done <= 1'b0;
            sat_flag   <= 1'b0;
        end else begin
            stage_v <= wr_go;
            if (wr_go) begin
                stage_acc  <= wr_acc;
                stage_addr <= wr_addr;
                stage_data <= wr_data;
            end
            rd_valid <= rd_go;
            if (rd_go) rd_data <= mem[rd_addr];
            sat_flag   <= !clr_go && (sat_ev || sat_flag);
            clear_done <= 1'b0;
            if (idle) begin
                if (clear_start) begin
                    state <= CLEAR;
                    cnt   <= '0;
                end
            end else begin
                cnt <= cnt + 1'b1;
                if (cnt == LAST) begin
                    state      <= IDLE;
                    clear_done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ofmd_acc_ram.sv
// tb_ofmd_acc_ram: directed self-checking bench for ofmd_acc_ram
module tb_ofmd_acc_ram;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0, wr_acc = 1'b0, rd_en = 1'b0, clear_start = 1'b0;
    logic [5:0] wr_addr = '0, rd_addr = '0;
    logic [7:0] wr_data = '0;
    logic [7:0] rd_data;
    logic       rd_valid, busy, clear_done, sat_flag;
    int         checks = 0, fails = 0, k;

    ofmd_acc_ram dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_acc(wr_acc), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .clear_start(clear_start), .busy(busy),
        .clear_done(clear_done), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d, input logic acc);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_acc = acc;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [5:0] a, input logic [7:0] exp);
        rd_en = 1'b1; rd_addr = a;
        tick();
        rd_en = 1'b0;
        chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
        chk(tag, 32'(rd_data), 32'(exp));
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!clear_done && n < 200) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #12;
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_clear_done", 32'(clear_done), 0);
        chk("rst_sat_flag", 32'(sat_flag), 0);
        rst_n = 1'b1;
        tick();
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        chk("clr_busy", 32'(busy), 1);
        wait_done(k);
        chk("clr_cycles", 32'(k), 64);
        chk("clr_busy_end", 32'(busy), 0);
        tick();
        chk("clr_done_pulse", 32'(clear_done), 0);
        rd("rd0", 6'd0, 8'h00);
        rd("rd31", 6'd31, 8'h00);
        rd("rd63", 6'd63, 8'h00);
        tick();
        chk("rd_valid_drop", 32'(rd_valid), 0);
        chk("rd_hold", 32'(rd_data), 0);

        wr(6'd5, 8'h12, 1'b0);
        wr_en = 1'b1; wr_acc = 1'b1; wr_addr = 6'd5; wr_data = 8'h03;
        repeat (4) tick();
        wr_en = 1'b0;
        tick();
        rd("acc5", 6'd5, 8'h1E);
        chk("acc5_sat", 32'(sat_flag), 0);

        wr(6'd9, 8'hF0, 1'b0);
        wr(6'd9, 8'h20, 1'b1);
        tick();
        chk("sat9_flag", 32'(sat_flag), 1);
        rd("sat9", 6'd9, 8'hFF);

        wr(6'd3, 8'h11, 1'b0);
        tick();
        wr(6'd3, 8'h22, 1'b0);
        rd("coll3_old", 6'd3, 8'h11);
        rd("coll3_new", 6'd3, 8'h22);
        wr_en = 1'b1; wr_addr = 6'd3; wr_data = 8'h33; wr_acc = 1'b0;
        rd("stage3_old", 6'd3, 8'h22);
        tick();
        rd("stage3_new", 6'd3, 8'h33);
        chk("sat_sticky", 32'(sat_flag), 1);

        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        chk("clr2_sat_clr", 32'(sat_flag), 0);
        chk("clr2_busy", 32'(busy), 1);
        repeat (20) tick();
        wr_en = 1'b1; wr_acc = 1'b0; wr_addr = 6'd5; wr_data = 8'hAA;
        rd_en = 1'b1; rd_addr = 6'd5;
        tick();
        chk("busy_no_rd_valid", 32'(rd_valid), 0);
        tick();
        chk("busy_rd_hold", 32'(rd_data), 32'h33);
        wr_en = 1'b0; rd_en = 1'b0;
        wait_done(k);
        chk("clr2_done", 32'(clear_done), 1);
        rd("busy_wr_ignored", 6'd5, 8'h00);
        rd("clr2_9", 6'd9, 8'h00);

        wr(6'd9, 8'hF0, 1'b0);
        wr(6'd9, 8'h20, 1'b1);
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        chk("sat_prec", 32'(sat_flag), 0);
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        tick();
        rst_n = 1'b1;
        k = 0;
        repeat (80) begin
            tick();
            if (clear_done) k++;
        end
        chk("midrst_no_done", 32'(k), 0);
        chk("midrst_idle", 32'(busy), 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
